// File: rtl/arm_controller.sv
// arm_controller: single-cycle ARM control unit.
// Decodes Instr[31:12] into datapath strobes and holds the NZCV flag register.
// State-changing strobes are gated by the conditional-execution check.
module arm_controller #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags
);

  // Instr is bits [31:12], so local index = architectural index - 12.
  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] rd_s;
  logic       unused_rn_s;

  assign cond_s      = Instr[19:16];
  assign op_s        = Instr[15:14];
  assign funct_s     = Instr[13:8];
  assign rd_s        = Instr[3:0];
  // Rn does not affect control decode.
  assign unused_rn_s = ^Instr[7:4];

  // ARM condition-code evaluation against a packed {N,Z,C,V}.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n;
    logic z;
    logic c;
    logic v;
    logic r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic       branch_s;
  logic       reg_w_s;
  logic       mem_w_s;
  logic       alu_op_s;
  logic       mem_to_reg_s;
  logic       alu_src_s;
  logic [1:0] reg_src_s;
  logic [1:0] imm_src_s;
  logic [1:0] alu_control_s;
  logic       cmd_ok_s;
  logic       reg_w_eff_s;
  logic [1:0] flag_w_s;
  logic       pcs_s;
  logic       cond_ex_s;
  logic [3:0] flags_q;
  logic [3:0] flags_d;

  // Main decode: instruction class to raw (ungated) strobes.
  always_comb begin
    branch_s     = 1'b0;
    reg_w_s      = 1'b0;
    mem_w_s      = 1'b0;
    alu_op_s     = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_s    = 1'b0;
    reg_src_s    = 2'b00;
    imm_src_s    = 2'b00;
    case (op_s)
      2'b00: begin
        alu_src_s = funct_s[5];
        reg_w_s   = 1'b1;
        alu_op_s  = 1'b1;
      end
      2'b01: begin
        imm_src_s = 2'b01;
        alu_src_s = 1'b1;
        if (funct_s[0]) begin
          mem_to_reg_s = 1'b1;
          reg_w_s      = 1'b1;
        end else begin
          reg_src_s = 2'b10;
          mem_w_s   = 1'b1;
        end
      end
      2'b10: begin
        branch_s  = 1'b1;
        reg_src_s = 2'b01;
        imm_src_s = 2'b10;
        alu_src_s = 1'b1;
      end
      default: begin
        // Undefined class: everything stays deasserted.
        branch_s = 1'b0;
      end
    endcase
  end

  // ALU decode: map DP command to ALU operation; unknown commands become no-ops.
  always_comb begin
    alu_control_s = 2'b00;
    cmd_ok_s      = 1'b1;
    if (alu_op_s) begin
      case (funct_s[4:1])
        4'b0100: alu_control_s = 2'b00;
        4'b0010: alu_control_s = 2'b01;
        4'b0000: alu_control_s = 2'b10;
        4'b1100: alu_control_s = 2'b11;
        default: begin
          alu_control_s = 2'b00;
          cmd_ok_s      = 1'b0;
        end
      endcase
    end else begin
      alu_control_s = 2'b00;
      cmd_ok_s      = 1'b1;
    end
  end

  assign reg_w_eff_s = reg_w_s & cmd_ok_s;
  // C,V are only meaningful for the arithmetic ops (ADD/SUB have ALUControl[1]=0).
  assign flag_w_s[1] = alu_op_s & funct_s[0] & cmd_ok_s;
  assign flag_w_s[0] = flag_w_s[1] & ~alu_control_s[1];
  assign pcs_s       = branch_s | (reg_w_eff_s & (rd_s == 4'hF));

  // The condition uses the registered flags, so a flag-setting instruction sees the old flags.
  assign cond_ex_s = cond_holds(cond_s, flags_q);

  assign PCSrc      = pcs_s & cond_ex_s;
  assign RegWrite   = reg_w_eff_s & cond_ex_s;
  assign MemWrite   = mem_w_s & cond_ex_s;
  assign MemtoReg   = mem_to_reg_s;
  assign ALUSrc     = alu_src_s;
  assign RegSrc     = reg_src_s;
  assign ImmSrc     = imm_src_s;
  assign ALUControl = alu_control_s;
  assign Flags      = flags_q;

  // Next flags: each half loads independently, and only when the instruction executes.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex_s) begin
      if (flag_w_s[1]) begin
        flags_d[3:2] = ALUFlags[3:2];
      end else begin
        flags_d[3:2] = flags_q[3:2];
      end
      if (flag_w_s[0]) begin
        flags_d[1:0] = ALUFlags[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // NZCV register with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags_q <= FLAGS_RESET;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: doc/arm_controller.md
Name: arm_controller

Overview:
- Single-cycle control unit sitting directly upstream of the datapath.
- Decodes Instr[31:12] into the datapath control strobes (PCSrc, MemtoReg, MemWrite, ALUSrc, RegWrite, RegSrc, ImmSrc, ALUControl).
- Holds the architectural NZCV condition-flag register, updated from the datapath's ALUFlags.
- Gates all state-changing strobes with ARM conditional-execution logic.

Parameters:
- FLAGS_RESET, 4'b0000, value loaded into the NZCV register on reset (bit3=N, bit2=Z, bit1=C, bit0=V).

Ports:
- CLK  input  1  system clock; flag register updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Instr  input  20  Instr[31:12] of the current instruction: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- ALUFlags  input  4  NZCV from the datapath ALU for the current instruction.
- PCSrc  output  1  select branch/ALU Result as the next PC.
- MemtoReg  output  1  write-back selects memory read data.
- MemWrite  output  1  data memory write enable.
- ALUSrc  output  1  ALU B operand is the extended immediate.
- RegWrite  output  1  register file write enable.
- RegSrc  output  2  bit0 selects R15 as RA1; bit1 selects Rd as RA2.
- ImmSrc  output  2  00 = 8-bit DP immediate, 01 = 12-bit memory offset, 10 = 24-bit branch offset.
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- Flags  output  4  current registered NZCV, for observation.

Behaviour:

Decode (combinational from Instr):
- Op=00, data processing:
  - RegSrc=00, ImmSrc=00, ALUSrc=Funct[5], MemtoReg=0, RegW=1, MemW=0, Branch=0, ALUOp=1.
- Op=01, memory, LDR when Funct[0]=1:
  - LDR: RegSrc=00, ImmSrc=01, ALUSrc=1, MemtoReg=1, RegW=1, MemW=0.
  - STR: RegSrc=10, ImmSrc=01, ALUSrc=1, MemtoReg=0, RegW=0, MemW=1.
  - Branch=0, ALUOp=0 for both.
- Op=10, branch:
  - RegSrc=01, ImmSrc=10, ALUSrc=1, MemtoReg=0, RegW=0, MemW=0, Branch=1, ALUOp=0.
- Op=11, undefined: all strobes 0, RegSrc=00, ImmSrc=00, ALUControl=00, no flag write.

ALU decode:
- ALUOp=0: ALUControl=00.
- ALUOp=1, cmd=Funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11.
- Any other cmd: ALUControl=00, RegW forced 0, FlagW forced 00 (treated as no-op).
- FlagW[1] (N,Z) = ALUOp & Funct[0].
- FlagW[0] (C,V) = ALUOp & Funct[0] & (ALUControl is 00 or 01).
- PCS = Branch | (RegW & Rd==4'hF).

Condition check (combinational on registered Flags, not on ALUFlags):
- 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
- 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
- 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V.
- 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never (0).
- Gating: PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx.
- MemtoReg, ALUSrc, RegSrc, ImmSrc and ALUControl are not gated.

Flag register:
- On posedge CLK, if CondEx: FlagW[1] loads Flags[3:2]←ALUFlags[3:2]; FlagW[0] loads Flags[1:0]←ALUFlags[1:0]. Each half updates independently.
- Latency: new flags are visible to the next instruction's condition check, one cycle later.
- An instruction that both tests and sets flags uses the old flags for CondEx.
- A failed-condition instruction never updates flags.

Reset:
- RESET=1 asynchronously forces Flags=FLAGS_RESET, taking effect immediately, including mid-cycle.
- While RESET=1 the flags hold; strobes remain a combinational function of Instr and FLAGS_RESET.
- Reset output values (FLAGS_RESET=0000, Instr=0): EQ fails, so PCSrc=RegWrite=MemWrite=0; Flags=0000.
- First capture after deassertion happens on the first rising edge with RESET=0.

Test Plan:
- Reset then AL ADD (Instr[31:12]=E0810): RegWrite=1, ALUControl=00, ALUSrc=0, PCSrc=0, MemWrite=0, Flags stay 0000 (S=0).
- SUBS with ALUFlags=0100, then EQ ADD next cycle: Flags=0100 after the edge; second instruction RegWrite=1. Repeat with ALUFlags=0000: RegWrite=0.
- ANDS with ALUFlags=1011 starting from Flags=0011: only N,Z update, so Flags=1011 with C,V preserved; a following ANDS with ALUFlags=0000 gives Flags=0011.
- STR (E58..., Funct[0]=0): MemWrite=1, RegWrite=0, RegSrc=10, ImmSrc=01; same instruction with Cond=0000 and Z=0: MemWrite=0.
- AL branch (EA...): PCSrc=1, ImmSrc=10, RegSrc=01, ALUControl=00. DP instruction with Rd=15: PCSrc=1 and RegWrite=1. Cond=1111: all gated strobes 0.
- Assert RESET asynchronously between edges while Flags=1111: Flags=0000 immediately, before the next CLK edge; GT instruction afterwards gives CondEx=1.
